// File: rtl/backprop_scheduler.sv
// Token sequencer for the backpropagation datapath: issues one sample token and the
// layer tokens LAYER_MAX-1..0 per sample, one sample in flight, gated by write-back retirement.
module backprop_scheduler #(
    parameter int LAYER_ADDR_WIDTH = 2,
    parameter int LAYER_MAX        = 3,
    parameter int SAMPLE_ADDR_SIZE = 10,
    parameter int SAMPLE_NUM       = 1000,
    parameter int EPOCH_WIDTH      = 16,
    parameter int ABORT_ON_ERROR   = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [EPOCH_WIDTH-1:0]      epochs,
    output logic                        busy,
    output logic                        done,
    output logic [LAYER_ADDR_WIDTH-1:0] layer,
    output logic                        layer_valid,
    input  logic                        layer_ready,
    output logic [SAMPLE_ADDR_SIZE-1:0] sample,
    output logic                        sample_valid,
    input  logic                        sample_ready,
    input  logic                        wb_valid,
    input  logic                        wb_ready,
    input  logic                        error,
    output logic                        error_flag,
    output logic [EPOCH_WIDTH-1:0]      cur_epoch,
    output logic [SAMPLE_ADDR_SIZE-1:0] cur_sample
);

    localparam int RETIRE_W = $clog2(LAYER_MAX + 1);
    localparam logic [RETIRE_W-1:0]         RETIRE_MAX  = RETIRE_W'(LAYER_MAX);
    localparam logic [RETIRE_W-1:0]         RETIRE_ONE  = RETIRE_W'(1);
    localparam logic [RETIRE_W-1:0]         RETIRE_ZERO = RETIRE_W'(0);
    localparam logic [LAYER_ADDR_WIDTH-1:0] LAYER_TOP   = LAYER_ADDR_WIDTH'(LAYER_MAX - 1);
    localparam logic [LAYER_ADDR_WIDTH-1:0] LAYER_ONE   = LAYER_ADDR_WIDTH'(1);
    localparam logic [LAYER_ADDR_WIDTH-1:0] LAYER_ZERO  = LAYER_ADDR_WIDTH'(0);
    localparam logic [SAMPLE_ADDR_SIZE-1:0] SAMPLE_LAST = SAMPLE_ADDR_SIZE'(SAMPLE_NUM - 1);
    localparam logic [SAMPLE_ADDR_SIZE-1:0] SAMPLE_ONE  = SAMPLE_ADDR_SIZE'(1);
    localparam logic [SAMPLE_ADDR_SIZE-1:0] SAMPLE_ZERO = SAMPLE_ADDR_SIZE'(0);
    localparam logic [EPOCH_WIDTH-1:0]      EPOCH_ONE   = EPOCH_WIDTH'(1);
    localparam logic [EPOCH_WIDTH-1:0]      EPOCH_ZERO  = EPOCH_WIDTH'(0);
    localparam bit                          ABORT_EN    = (ABORT_ON_ERROR != 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                      state_r;
    logic [EPOCH_WIDTH-1:0]      epochs_r;
    logic [RETIRE_W-1:0]         retire_r;
    logic                        sample_sent_r;
    logic                        layer_sent_r;

    logic                        layer_fire_s;
    logic                        sample_fire_s;
    logic                        wb_fire_s;
    logic                        counting_s;
    logic [RETIRE_W-1:0]         retire_next_s;
    logic                        overfire_s;
    logic                        sample_done_s;
    logic                        layer_done_s;
    logic                        last_sample_s;
    logic [EPOCH_WIDTH-1:0]      epoch_next_s;
    logic [SAMPLE_ADDR_SIZE-1:0] sample_next_s;
    logic                        abort_s;

    assign layer_fire_s  = layer_valid & layer_ready;
    assign sample_fire_s = sample_valid & sample_ready;
    assign wb_fire_s     = wb_valid & wb_ready;
    assign counting_s    = (state_r == S_ISSUE) || (state_r == S_DRAIN);
    assign sample_done_s = sample_sent_r | sample_fire_s;
    assign layer_done_s  = layer_sent_r | (layer_fire_s & (layer == LAYER_ZERO));
    assign last_sample_s = (cur_sample == SAMPLE_LAST);
    assign epoch_next_s  = cur_epoch + EPOCH_ONE;
    assign sample_next_s = last_sample_s ? SAMPLE_ZERO : (cur_sample + SAMPLE_ONE);
    assign abort_s       = ABORT_EN & error_flag;

    // Saturating retire count; a write-back beyond LAYER_MAX is flagged instead of counted
    always_comb begin
        retire_next_s = retire_r;
        overfire_s    = 1'b0;
        if (counting_s && wb_fire_s) begin
            if (retire_r == RETIRE_MAX) begin
                overfire_s = 1'b1;
            end else begin
                retire_next_s = retire_r + RETIRE_ONE;
            end
        end else begin
            retire_next_s = retire_r;
        end
    end

    // Sequencer state, token channels, counters and sticky error flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r       <= S_IDLE;
            epochs_r      <= EPOCH_ZERO;
            retire_r      <= RETIRE_ZERO;
            sample_sent_r <= 1'b0;
            layer_sent_r  <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            layer         <= LAYER_ZERO;
            layer_valid   <= 1'b0;
            sample        <= SAMPLE_ZERO;
            sample_valid  <= 1'b0;
            error_flag    <= 1'b0;
            cur_epoch     <= EPOCH_ZERO;
            cur_sample    <= SAMPLE_ZERO;
        end else begin
            case (state_r)
                S_IDLE: begin
                    busy <= 1'b0;
                    done <= 1'b0;
                    if (start) begin
                        epochs_r      <= epochs;
                        error_flag    <= 1'b0;
                        cur_epoch     <= EPOCH_ZERO;
                        cur_sample    <= SAMPLE_ZERO;
                        retire_r      <= RETIRE_ZERO;
                        sample_sent_r <= 1'b0;
                        layer_sent_r  <= 1'b0;
                        busy          <= 1'b1;
                        if (epochs == EPOCH_ZERO) begin
                            state_r <= S_DONE;
                            done    <= 1'b1;
                        end else begin
                            state_r      <= S_ISSUE;
                            sample       <= SAMPLE_ZERO;
                            sample_valid <= 1'b1;
                            layer        <= LAYER_TOP;
                            layer_valid  <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    retire_r <= retire_next_s;
                    if (sample_fire_s) begin
                        sample_valid  <= 1'b0;
                        sample_sent_r <= 1'b1;
                    end
                    if (layer_fire_s) begin
                        if (layer == LAYER_ZERO) begin
                            layer_valid  <= 1'b0;
                            layer_sent_r <= 1'b1;
                        end else begin
                            layer <= layer - LAYER_ONE;
                        end
                    end
                    if (sample_done_s && layer_done_s) begin
                        state_r <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (retire_next_s == RETIRE_MAX) begin
                        retire_r      <= RETIRE_ZERO;
                        sample_sent_r <= 1'b0;
                        layer_sent_r  <= 1'b0;
                        if (last_sample_s && (epoch_next_s == epochs_r)) begin
                            cur_sample <= SAMPLE_ZERO;
                            cur_epoch  <= epoch_next_s;
                            state_r    <= S_DONE;
                            done       <= 1'b1;
                        end else if (abort_s) begin
                            // Abort keeps cur_sample on the sample that just drained
                            state_r <= S_DONE;
                            done    <= 1'b1;
                        end else begin
                            if (last_sample_s) begin
                                cur_epoch <= epoch_next_s;
                            end
                            cur_sample   <= sample_next_s;
                            sample       <= sample_next_s;
                            sample_valid <= 1'b1;
                            layer        <= LAYER_TOP;
                            layer_valid  <= 1'b1;
                            state_r      <= S_ISSUE;
                        end
                    end else begin
                        retire_r <= retire_next_s;
                    end
                end
                S_DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= S_IDLE;
                end
                default: begin
                    state_r      <= S_IDLE;
                    busy         <= 1'b0;
                    done         <= 1'b0;
                    layer_valid  <= 1'b0;
                    sample_valid <= 1'b0;
                end
            endcase
            if (busy && (error || overfire_s)) begin
                error_flag <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_backprop_scheduler.sv
// Directed bench for backprop_scheduler: two instances (abort on / abort off) with
// hand-computed token orders, cycle counts and flag values.
module tb_backprop_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        start_b = 1'b0;
    logic [15:0] epochs = 16'd0;
    logic        layer_ready = 1'b1;
    logic        sample_ready = 1'b1;
    logic        wb_ready = 1'b1;
    logic        error = 1'b0;
    logic        wb_man = 1'b0;
    logic        auto_en = 1'b1;

    logic        busy_a, done_a, layer_valid_a, sample_valid_a, error_flag_a;
    logic [1:0]  layer_a;
    logic [9:0]  sample_a, cur_sample_a;
    logic [15:0] cur_epoch_a;
    logic        busy_b, done_b, layer_valid_b, sample_valid_b, error_flag_b;
    logic [1:0]  layer_b;
    logic [9:0]  sample_b, cur_sample_b;
    logic [15:0] cur_epoch_b;
    logic [1:0]  pipe_a, pipe_b;
    logic        wb_valid_a, wb_valid_b;

    int tests = 0;
    int fails = 0;
    int lq[$];
    int sq[$];

    always #5 clk = ~clk;

    // write-back model: one fire two cycles after each layer transfer
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            pipe_a <= 2'b00;
            pipe_b <= 2'b00;
        end else begin
            pipe_a <= {pipe_a[0], layer_valid_a & layer_ready};
            pipe_b <= {pipe_b[0], layer_valid_b & layer_ready};
        end
    end
    assign wb_valid_a = auto_en ? pipe_a[1] : wb_man;
    assign wb_valid_b = pipe_b[1];

    always @(posedge clk) begin
        if (rst) begin
            if (layer_valid_a && layer_ready) lq.push_back(int'(layer_a));
            if (sample_valid_a && sample_ready) sq.push_back(int'(sample_a));
        end
    end

    backprop_scheduler #(.LAYER_ADDR_WIDTH(2), .LAYER_MAX(3), .SAMPLE_ADDR_SIZE(10),
                         .SAMPLE_NUM(4), .EPOCH_WIDTH(16), .ABORT_ON_ERROR(1)) dut_a (
        .clk(clk), .rst(rst), .start(start), .epochs(epochs), .busy(busy_a), .done(done_a),
        .layer(layer_a), .layer_valid(layer_valid_a), .layer_ready(layer_ready),
        .sample(sample_a), .sample_valid(sample_valid_a), .sample_ready(sample_ready),
        .wb_valid(wb_valid_a), .wb_ready(wb_ready), .error(error), .error_flag(error_flag_a),
        .cur_epoch(cur_epoch_a), .cur_sample(cur_sample_a));

    backprop_scheduler #(.LAYER_ADDR_WIDTH(2), .LAYER_MAX(3), .SAMPLE_ADDR_SIZE(10),
                         .SAMPLE_NUM(4), .EPOCH_WIDTH(16), .ABORT_ON_ERROR(0)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .epochs(epochs), .busy(busy_b), .done(done_b),
        .layer(layer_b), .layer_valid(layer_valid_b), .layer_ready(layer_ready),
        .sample(sample_b), .sample_valid(sample_valid_b), .sample_ready(sample_ready),
        .wb_valid(wb_valid_b), .wb_ready(wb_ready), .error(error), .error_flag(error_flag_b),
        .cur_epoch(cur_epoch_b), .cur_sample(cur_sample_b));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_seq(input string tag, input int got[$], input int exp[$]);
        check({tag, "_len"}, got.size(), exp.size());
        for (int i = 0; i < got.size() && i < exp.size(); i++) check(tag, got[i], exp[i]);
    endtask

    // Run until done (and done_b if wanted) is seen, with optional backpressure and hold checks
    task automatic run(input int limit, input int bp, input int want_b,
                       output int n_a, output int n_b, output int pa, output int pb,
                       output logic bd, output logic ba);
        logic lv, lr, sv, sr;
        logic [1:0] ld;
        logic [9:0] sd;
        n_a = -1; n_b = -1; pa = 0; pb = 0; bd = 1'b0; ba = 1'b1;
        for (int i = 1; i <= limit; i++) begin
            if (bp != 0) begin
                layer_ready  = (i % 3 != 0);
                sample_ready = (i % 2 == 0);
            end
            lv = layer_valid_a; lr = layer_ready; ld = layer_a;
            sv = sample_valid_a; sr = sample_ready; sd = sample_a;
            tick();
            if (lv && !lr) check("layer_hold", {layer_valid_a, layer_a}, {1'b1, ld});
            if (sv && !sr) check("sample_hold", {sample_valid_a, sample_a}, {1'b1, sd});
            if (done_a) begin
                pa++;
                if (n_a < 0) begin n_a = i; bd = busy_a; end
            end
            if (n_a >= 0 && i == n_a + 1) ba = busy_a;
            if (done_b) begin
                pb++;
                if (n_b < 0) n_b = i;
            end
            if (n_a >= 0 && (want_b == 0 || n_b >= 0) && i >= n_a + 3 && i >= n_b + 3) break;
        end
        layer_ready = 1'b1;
        sample_ready = 1'b1;
    endtask

    initial begin
        int n_a, n_b, pa, pb;
        logic bd, ba;
        int lexp[$];
        int sexp[$];

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {busy_a, done_a, layer_valid_a, sample_valid_a, layer_a, sample_a,
                                error_flag_a, cur_epoch_a, cur_sample_a}, 64'd0);
        rst = 1'b1;
        tick();

        // epochs == 0: done the cycle after start, no tokens
        lq.delete(); sq.delete();
        epochs = 16'd0; start = 1'b1;
        tick();
        start = 1'b0;
        check("zero_ep_done", done_a, 1'b1);
        check("zero_ep_busy", busy_a, 1'b1);
        check("zero_ep_valids", {layer_valid_a, sample_valid_a}, 2'b00);
        tick();
        check("zero_ep_done_end", {done_a, busy_a}, 2'b00);
        check("zero_ep_tokens", lq.size() + sq.size(), 0);

        // two epochs, full throughput; start while busy is ignored
        lq.delete(); sq.delete();
        epochs = 16'd2; start = 1'b1;
        tick();
        start = 1'b0;
        check("t1_first_tokens", {busy_a, sample_valid_a, sample_a, layer_valid_a, layer_a},
              {1'b1, 1'b1, 10'd0, 1'b1, 2'd2});
        start = 1'b1; epochs = 16'd7;
        tick();
        start = 1'b0; epochs = 16'd2;
        check("t1_after_first_xfer", {busy_a, sample_valid_a, layer_valid_a, layer_a},
              {1'b1, 1'b0, 1'b1, 2'd1});
        run(200, 0, 0, n_a, n_b, pa, pb, bd, ba);
        check("t1_done_cycle", n_a, 39);
        check("t1_done_pulses", pa, 1);
        check("t1_busy_at_done", bd, 1'b1);
        check("t1_busy_after_done", ba, 1'b0);
        check("t1_cur_epoch", cur_epoch_a, 16'd2);
        check("t1_cur_sample", cur_sample_a, 10'd0);
        check("t1_error_flag", error_flag_a, 1'b0);
        lexp.delete(); sexp.delete();
        for (int s = 0; s < 8; s++) begin
            sexp.push_back(s % 4);
            for (int l = 2; l >= 0; l--) lexp.push_back(l);
        end
        check_seq("t1_layers", lq, lexp);
        check_seq("t1_samples", sq, sexp);

        // backpressure; sample 0 token held 10 cycles after its layers are accepted
        lq.delete(); sq.delete();
        epochs = 16'd1; sample_ready = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 50 && lq.size() < 3; i++) begin
            layer_ready = (i % 2 == 1);
            tick();
        end
        layer_ready = 1'b1;
        repeat (10) tick();
        check("t2_sample_held", {sample_valid_a, sample_a, layer_valid_a}, {1'b1, 10'd0, 1'b0});
        check("t2_no_advance", cur_sample_a, 10'd0);
        check("t2_no_sample_xfer", sq.size(), 0);
        run(600, 1, 0, n_a, n_b, pa, pb, bd, ba);
        check("t2_done_pulses", pa, 1);
        check("t2_cur_epoch", cur_epoch_a, 16'd1);
        lexp.delete(); sexp.delete();
        for (int s = 0; s < 4; s++) begin
            sexp.push_back(s);
            for (int l = 2; l >= 0; l--) lexp.push_back(l);
        end
        check_seq("t2_layers", lq, lexp);
        check_seq("t2_samples", sq, sexp);

        // withheld write-back, then a spurious fourth fire
        lq.delete(); sq.delete();
        auto_en = 1'b0; wb_man = 1'b0;
        epochs = 16'd1; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        check("t3_s0_tokens", {lq.size(), sq.size()}, {32'd3, 32'd1});
        repeat (50) tick();
        check("t3_wait_valids", {sample_valid_a, layer_valid_a}, 2'b00);
        wb_man = 1'b1;
        repeat (2) tick();
        wb_man = 1'b0;
        tick();
        check("t3_two_fires_hold", {sample_valid_a, cur_sample_a}, {1'b0, 10'd0});
        wb_man = 1'b1; layer_ready = 1'b0; sample_ready = 1'b0;
        tick();
        check("t3_third_fire_issue", {sample_valid_a, sample_a, layer_valid_a, layer_a, cur_sample_a},
              {1'b1, 10'd1, 1'b1, 2'd2, 10'd1});
        repeat (3) tick();
        check("t3_three_fires_ok", error_flag_a, 1'b0);
        tick();
        check("t3_fourth_fire_err", error_flag_a, 1'b1);
        wb_man = 1'b0; layer_ready = 1'b1; sample_ready = 1'b1;
        run(100, 0, 0, n_a, n_b, pa, pb, bd, ba);
        check("t3_abort_cycle", n_a, 4);
        check("t3_cur_sample", cur_sample_a, 10'd1);
        check("t3_error_kept", error_flag_a, 1'b1);
        sexp.delete(); sexp.push_back(0); sexp.push_back(1);
        check_seq("t3_samples", sq, sexp);
        auto_en = 1'b1;

        // error pulse during sample 1: abort instance stops, other completes
        lq.delete(); sq.delete();
        epochs = 16'd1; start = 1'b1; start_b = 1'b1;
        tick();
        start = 1'b0; start_b = 1'b0;
        check("t5_start_clears_err", error_flag_a, 1'b0);
        repeat (6) tick();
        error = 1'b1;
        tick();
        error = 1'b0;
        run(200, 0, 1, n_a, n_b, pa, pb, bd, ba);
        check("t5_abort_cycle", n_a, 3);
        check("t5_full_cycle", n_b, 13);
        check("t5_pulses", {pa, pb}, {32'd1, 32'd1});
        check("t5_abort_state", {error_flag_a, cur_sample_a, cur_epoch_a}, {1'b1, 10'd1, 16'd0});
        check("t5_full_state", {error_flag_b, cur_sample_b, cur_epoch_b}, {1'b1, 10'd0, 16'd1});
        check("t5_layers_len", lq.size(), 6);

        // asynchronous reset mid-issue, then a clean run
        epochs = 16'd1; sample_ready = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        error = 1'b1;
        tick();
        error = 1'b0;
        check("t6_pre_reset", {layer_valid_a, error_flag_a}, 2'b11);
        rst = 1'b0;
        #1;
        check("t6_async_reset", {busy_a, done_a, layer_valid_a, sample_valid_a, layer_a, sample_a,
                                 error_flag_a, cur_epoch_a, cur_sample_a}, 64'd0);
        tick();
        tick();
        check("t6_no_done", {done_a, busy_a}, 2'b00);
        rst = 1'b1; sample_ready = 1'b1;
        tick();
        lq.delete(); sq.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
        run(200, 0, 0, n_a, n_b, pa, pb, bd, ba);
        check("t6_done_cycle", n_a, 20);
        check("t6_state", {pa, 16'(cur_epoch_a), 1'(error_flag_a)}, {32'd1, 16'd1, 1'b0});
        sexp.delete();
        for (int s = 0; s < 4; s++) sexp.push_back(s);
        check_seq("t6_samples", sq, sexp);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/backprop_scheduler.md
Name: backprop_scheduler

Overview:
Sequencer that drives the backpropagation datapath's layer and sample token inputs for a training run of N epochs over SAMPLE_NUM samples. For each sample it issues one sample index and then the layer indices LAYER_MAX-1 down to 0. It counts weight write-back handshakes and keeps at most one sample in flight. It sits between the training top-level control and the backpropagation datapath, and it latches datapath overflow errors.

Parameters:
LAYER_ADDR_WIDTH, 2, width of layer index
LAYER_MAX, 3, layers per sample; layers issued are LAYER_MAX-1 .. 0
SAMPLE_ADDR_SIZE, 10, width of sample index
SAMPLE_NUM, 1000, samples per epoch; must be in 1..2^SAMPLE_ADDR_SIZE
EPOCH_WIDTH, 16, width of epoch count/counter
ABORT_ON_ERROR, 1, 1 = stop issuing new samples after an error

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-low
start  in  1  single-cycle start request; honoured only in IDLE
epochs  in  EPOCH_WIDTH  epoch count, sampled when start is accepted
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when the run completes or aborts
layer  out  LAYER_ADDR_WIDTH  layer token to the datapath
layer_valid  out  1  layer token valid
layer_ready  in  1  layer token accepted
sample  out  SAMPLE_ADDR_SIZE  sample token to the datapath
sample_valid  out  1  sample token valid
sample_ready  in  1  sample token accepted
wb_valid  in  1  monitored weight write-back valid
wb_ready  in  1  monitored weight write-back ready
error  in  1  datapath overflow flag
error_flag  out  1  sticky error flag; cleared only by reset or an accepted start
cur_epoch  out  EPOCH_WIDTH  current epoch counter
cur_sample  out  SAMPLE_ADDR_SIZE  current sample counter

Behaviour:
- Reset (rst=0, async): state=IDLE. All outputs are 0: busy, done, layer_valid, sample_valid, layer, sample, error_flag, cur_epoch, cur_sample. Internal counters are 0.
- Handshake: a transfer occurs on a cycle where valid&ready=1.
  - Once valid is raised, it and its data are held stable until the transfer.
  - Valid never depends combinationally on ready.
  - The sample and layer channels are independent; both may transfer in the same cycle.
- wb fire = wb_valid&wb_ready. It is counted in ISSUE and DRAIN. A fire in IDLE or DONE is ignored.
- States:
  - IDLE: busy=0. On start=1, latch epochs and clear error_flag, cur_epoch, cur_sample, retire count.
    - If epochs==0, go to DONE.
    - Otherwise go to ISSUE. The cycle after start, sample_valid=1 with sample=cur_sample, and layer_valid=1 with layer=LAYER_MAX-1.
  - ISSUE:
    - The sample token is issued exactly once per sample.
    - Each layer transfer decrements layer. The transfer of layer 0 drops layer_valid.
    - When the sample token has transferred and the layer-0 token has transferred (same or different cycles), go to DRAIN on the next cycle.
  - DRAIN: no valids asserted. Wait until retire count == LAYER_MAX, including any fire in the current cycle. Then clear retire count and advance:
    - If cur_sample==SAMPLE_NUM-1: cur_sample wraps to 0 and cur_epoch increments. If cur_epoch+1==epochs, go to DONE.
    - Else if ABORT_ON_ERROR and error_flag, go to DONE.
    - Otherwise cur_sample+1, re-enter ISSUE with fresh tokens the next cycle.
  - DONE: done=1 for exactly one cycle, then IDLE. busy stays 1 in DONE.
- Retire count saturates at LAYER_MAX. A fire beyond LAYER_MAX for one sample is a protocol violation: it is ignored and also sets error_flag.
- error: error_flag <= 1 on any cycle with error=1 while busy. The in-flight sample always completes drain; it is never abandoned mid-sample.
- start while busy: ignored.
- Reset mid-run: immediate return to the reset state. Valids drop asynchronously, with no completion or done pulse.
- Minimum per-sample latency with ready=1 and an immediate write-back: 1 issue cycle per layer plus drain plus 1 advance cycle.

Test Plan:
1. LAYER_MAX=3, SAMPLE_NUM=4, epochs=2, readies tied 1, wb fires 2 cycles after each layer transfer -> layer sequence 2,1,0 per sample; samples 0,1,2,3,0,1,2,3; cur_epoch ends at 2 internally; exactly one done pulse; busy falls the cycle after done.
2. Random backpressure on layer_ready and sample_ready, with sample_ready delayed 10 cycles after all layers accepted -> tokens held stable while stalled; DRAIN entered only after the sample transfer; no duplicate or skipped tokens.
3. Withhold wb for 50 cycles after sample 0's layers -> no sample-1 tokens until the third wb fire; a 4th spurious fire sets error_flag.
4. epochs=0 with start -> no tokens issued, done pulse 1 cycle after start; start asserted while busy -> ignored.
5. ABORT_ON_ERROR=1, error pulse during sample 1 of 4 -> sample 1 drains fully, done asserted, error_flag=1, cur_sample=1. Repeat with ABORT_ON_ERROR=0 -> all samples complete, error_flag=1.
6. Assert rst=0 mid-ISSUE with layer_valid=1 -> all outputs 0 asynchronously, no done pulse; a subsequent start runs cleanly from sample 0.
